// File: rtl/ldpc_feeder.sv
// ldpc_feeder: pulls a deinterleaved frame codeword by codeword into the LDPC decoder,
// requesting CW_LEN soft bits per codeword and forwarding returned samples one cycle later.
module ldpc_feeder #(
  parameter int WID    = 6,
  parameter int CW_LEN = 9216,
  parameter int CW_NUM = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bidin_rdy,
  input  logic           bidin_ena_out,
  input  logic [WID-1:0] bidin_dout,
  input  logic           dec_rdy,
  output logic           ldpc_req,
  output logic           ldpc_fin,
  output logic           dec_start,
  output logic           dec_din_en,
  output logic [WID-1:0] dec_din,
  output logic           dec_last,
  output logic [3:0]     cw_idx,
  output logic           frm_ovf,
  output logic           rd_err
);

  typedef enum logic [2:0] {IDLE, WAIT_DEC, REQ, DRAIN, DONE} state_t;

  localparam logic [13:0] LEN_LAST = 14'(CW_LEN - 1);
  localparam logic [13:0] LEN_FULL = 14'(CW_LEN);
  localparam logic [3:0]  IDX_LAST = 4'(CW_NUM - 1);

  state_t         state_q, state_d;
  logic [13:0]    req_cnt_q, req_cnt_d;
  logic [13:0]    rcv_cnt_q, rcv_cnt_d;
  logic [3:0]     cw_idx_q, cw_idx_d;
  logic [3:0]     to_cnt_q, to_cnt_d;
  logic           pend_q, pend_d;
  logic           ldpc_req_q, ldpc_req_d;
  logic           ldpc_fin_q, ldpc_fin_d;
  logic           dec_start_q, dec_start_d;
  logic           dec_din_en_q, dec_din_en_d;
  logic [WID-1:0] dec_din_q, dec_din_d;
  logic           dec_last_q, dec_last_d;
  logic           frm_ovf_q, frm_ovf_d;
  logic           rd_err_q, rd_err_d;
  logic           rcv_phase, accept;

  always_comb begin
    state_d      = state_q;
    req_cnt_d    = req_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    cw_idx_d     = cw_idx_q;
    to_cnt_d     = to_cnt_q;
    pend_d       = pend_q;
    ldpc_fin_d   = 1'b0;
    dec_start_d  = 1'b0;
    dec_din_en_d = 1'b0;
    dec_din_d    = dec_din_q;
    dec_last_d   = 1'b0;
    frm_ovf_d    = frm_ovf_q;
    rd_err_d     = rd_err_q;

    // Samples are only taken while a codeword is open and not yet complete; anything else is an anomaly.
    rcv_phase = (state_q == REQ) || (state_q == DRAIN);
    accept    = bidin_ena_out && rcv_phase && (rcv_cnt_q != LEN_FULL);
    if (bidin_ena_out && !accept) rd_err_d = 1'b1;
    if (accept) begin
      rcv_cnt_d    = rcv_cnt_q + 14'd1;
      dec_din_en_d = 1'b1;
      dec_din_d    = bidin_dout;
      dec_last_d   = (rcv_cnt_q == LEN_LAST);
    end

    if (state_q != IDLE && bidin_rdy) begin
      if (pend_q) frm_ovf_d = 1'b1;
      else        pend_d    = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bidin_rdy || pend_q) begin
          state_d = WAIT_DEC;
          pend_d  = 1'b0;
          if (bidin_rdy && pend_q) frm_ovf_d = 1'b1;
        end
      end
      WAIT_DEC: begin
        if (dec_rdy) begin
          state_d     = REQ;
          dec_start_d = 1'b1;
        end
      end
      REQ: begin
        req_cnt_d = req_cnt_q + 14'd1;
        if (req_cnt_q == LEN_LAST) begin
          state_d  = DRAIN;
          to_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (rcv_cnt_q == LEN_FULL) begin
          req_cnt_d = '0;
          rcv_cnt_d = '0;
          to_cnt_d  = '0;
          if (cw_idx_q < IDX_LAST) begin
            cw_idx_d = cw_idx_q + 4'd1;
            state_d  = WAIT_DEC;
          end else begin
            state_d    = DONE;
            ldpc_fin_d = 1'b1;
          end
        end else if (bidin_ena_out) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == 4'hF) begin
          // Sixteenth silent cycle: abandon the frame rather than wait forever.
          rd_err_d   = 1'b1;
          ldpc_fin_d = 1'b1;
          req_cnt_d  = '0;
          rcv_cnt_d  = '0;
          to_cnt_d   = '0;
          cw_idx_d   = '0;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 4'd1;
        end
      end
      DONE: begin
        cw_idx_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ldpc_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_cnt_q    <= '0;
      rcv_cnt_q    <= '0;
      cw_idx_q     <= '0;
      to_cnt_q     <= '0;
      pend_q       <= 1'b0;
      ldpc_req_q   <= 1'b0;
      ldpc_fin_q   <= 1'b0;
      dec_start_q  <= 1'b0;
      dec_din_en_q <= 1'b0;
      dec_din_q    <= '0;
      dec_last_q   <= 1'b0;
      frm_ovf_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_cnt_q    <= req_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      cw_idx_q     <= cw_idx_d;
      to_cnt_q     <= to_cnt_d;
      pend_q       <= pend_d;
      ldpc_req_q   <= ldpc_req_d;
      ldpc_fin_q   <= ldpc_fin_d;
      dec_start_q  <= dec_start_d;
      dec_din_en_q <= dec_din_en_d;
      dec_din_q    <= dec_din_d;
      dec_last_q   <= dec_last_d;
      frm_ovf_q    <= frm_ovf_d;
      rd_err_q     <= rd_err_d;
    end
  end

  assign ldpc_req   = ldpc_req_q;
  assign ldpc_fin   = ldpc_fin_q;
  assign dec_start  = dec_start_q;
  assign dec_din_en = dec_din_en_q;
  assign dec_din    = dec_din_q;
  assign dec_last   = dec_last_q;
  assign cw_idx     = cw_idx_q;
  assign frm_ovf    = frm_ovf_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_ldpc_feeder.sv
// tb_ldpc_feeder: deinterleaver model with fixed latency feeding ldpc_feeder; returned samples
// are queued as expectations and matched against the decoder-side outputs.
module tb_ldpc_feeder;

  localparam int WID          = 6;
  localparam int CW_LEN       = 48;
  localparam int CW_NUM       = 15;
  localparam int LAT          = 3;
  localparam int FRAME_BUDGET = CW_NUM * (CW_LEN + 40) + 200;
  localparam int EV_START     = 0;
  localparam int EV_LAST      = 1;
  localparam int EV_FIN       = 2;

  typedef struct {
    logic [WID-1:0] data;
    logic           last;
    logic [3:0]     cw;
  } exp_t;

  logic           clk, rst_n, bidin_rdy, bidin_ena_out, dec_rdy;
  logic [WID-1:0] bidin_dout;
  logic           ldpc_req, ldpc_fin, dec_start, dec_din_en, dec_last, frm_ovf, rd_err;
  logic [WID-1:0] dec_din;
  logic [3:0]     cw_idx;

  int             tests_run = 0;
  int             tests_failed = 0;
  exp_t           sb[$];
  int             model_cnt = 0;
  int             model_cw = 0;
  bit             drop_mode = 0;
  bit             inject = 0;
  int             n_req = 0, n_fin = 0, n_start = 0, n_en = 0, n_last = 0, n_gap = 0;
  int             exp_cw = 0;
  bit             in_cw = 0;
  logic [WID-1:0] last_data = '0;
  int             cyc = 0, en_cyc = 0, fin_cyc = 0;

  ldpc_feeder #(.WID(WID), .CW_LEN(CW_LEN), .CW_NUM(CW_NUM)) dut (
    .clk(clk), .rst_n(rst_n), .bidin_rdy(bidin_rdy), .bidin_ena_out(bidin_ena_out),
    .bidin_dout(bidin_dout), .dec_rdy(dec_rdy), .ldpc_req(ldpc_req), .ldpc_fin(ldpc_fin),
    .dec_start(dec_start), .dec_din_en(dec_din_en), .dec_din(dec_din), .dec_last(dec_last),
    .cw_idx(cw_idx), .frm_ovf(frm_ovf), .rd_err(rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic drdy);
    step();
    bidin_rdy = rdy;
    dec_rdy   = drdy;
    step();
    bidin_rdy = 1'b0;
  endtask

  task automatic clearStats();
    n_req = 0; n_fin = 0; n_start = 0; n_en = 0; n_last = 0; n_gap = 0;
  endtask

  function automatic int cntOf(input int which);
    case (which)
      EV_START: return n_start;
      EV_LAST:  return n_last;
      default:  return n_fin;
    endcase
  endfunction

  task automatic waitFor(input int which, input int target, input int budget, input string tag);
    int spent = 0;
    while (cntOf(which) < target && spent < budget) begin
      step();
      spent++;
    end
    checkOutput(tag, int'(cntOf(which) >= target), 1);
  endtask

  // Deinterleaver: answers each request LAT cycles later with a random soft bit.
  initial begin : deint_model
    logic [LAT-1:0] pipe;
    logic           fire, skip;
    logic [WID-1:0] d;
    exp_t           e;
    pipe = '0;
    bidin_ena_out = 1'b0;
    bidin_dout = '0;
    forever begin
      @(negedge clk);
      bidin_ena_out = 1'b0;
      if (!rst_n) begin
        pipe = '0;
      end else begin
        fire = pipe[LAT-1];
        pipe = {pipe[LAT-2:0], ldpc_req};
        if (fire) begin
          skip = drop_mode && model_cw == 0 && model_cnt >= CW_LEN - 2;
          if (!skip) begin
            d = WID'($urandom_range(0, (1 << WID) - 1));
            bidin_ena_out = 1'b1;
            bidin_dout = d;
            e.data = d;
            e.last = (model_cnt == CW_LEN - 1);
            e.cw = 4'(model_cw);
            sb.push_back(e);
          end
          if (model_cnt == CW_LEN - 1) begin
            model_cnt = 0;
            model_cw = (model_cw + 1) % CW_NUM;
          end else begin
            model_cnt++;
          end
        end else if (inject) begin
          bidin_ena_out = 1'b1;
          bidin_dout = '1;
          inject = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        last_data = '0;
        in_cw = 0;
      end else begin
        if (ldpc_req) n_req++;
        if (ldpc_fin) begin
          n_fin++;
          fin_cyc = cyc;
        end
        if (dec_start) begin
          checkOutput("cw_at_start", int'(cw_idx), exp_cw);
          exp_cw = (exp_cw + 1) % CW_NUM;
          n_start++;
        end
        if (dec_din_en) begin
          n_en++;
          en_cyc = cyc;
          if (dec_last) n_last++;
          if (sb.size() == 0) begin
            checkOutput("sb_entry_for_en", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            checkOutput("dec_din", int'(dec_din), int'(e.data));
            checkOutput("dec_last", int'(dec_last), int'(e.last));
            checkOutput("cw_at_data", int'(cw_idx), int'(e.cw));
            last_data = e.data;
            in_cw = !e.last;
          end
        end else begin
          checkOutput("dec_last_idle", int'(dec_last), 0);
          checkOutput("dec_din_hold", int'(dec_din), int'(last_data));
          if (in_cw) n_gap++;
        end
      end
    end
  end

  initial begin : main
    int req_before, bad_idx;
    rst_n = 1'b1;
    bidin_rdy = 1'b0;
    dec_rdy = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) step();
    checkOutput("rst_ldpc_req", int'(ldpc_req), 0);
    checkOutput("rst_dec_din", int'(dec_din), 0);
    checkOutput("rst_cw_idx", int'(cw_idx), 0);
    checkOutput("rst_flags", int'({frm_ovf, rd_err, ldpc_fin, dec_start}), 0);
    rst_n = 1'b1;
    repeat (3) step();

    // Nominal frame
    clearStats();
    applyStimulus(1'b1, 1'b1);
    waitFor(EV_FIN, 1, FRAME_BUDGET, "nom_fin_seen");
    repeat (5) step();
    checkOutput("nom_starts", n_start, CW_NUM);
    checkOutput("nom_en", n_en, CW_NUM * CW_LEN);
    checkOutput("nom_last", n_last, CW_NUM);
    checkOutput("nom_fin", n_fin, 1);
    checkOutput("nom_req", n_req, CW_NUM * CW_LEN);
    checkOutput("nom_gap", n_gap, 0);
    checkOutput("nom_sb_empty", sb.size(), 0);
    checkOutput("nom_cw_idx", int'(cw_idx), 0);
    checkOutput("nom_err", int'({frm_ovf, rd_err}), 0);

    // Decoder stalls before codeword index 3
    clearStats();
    applyStimulus(1'b1, 1'b1);
    waitFor(EV_START, 3, FRAME_BUDGET, "stall_cw2_start");
    dec_rdy = 1'b0;
    waitFor(EV_LAST, 3, FRAME_BUDGET, "stall_cw2_last");
    step();
    step();
    req_before = n_req;
    bad_idx = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cw_idx != 4'd3) bad_idx++;
    end
    checkOutput("stall_req_total", req_before, 3 * CW_LEN);
    checkOutput("stall_no_req", n_req - req_before, 0);
    checkOutput("stall_cw_idx", bad_idx, 0);
    checkOutput("stall_starts", n_start, 3);
    dec_rdy = 1'b1;
    waitFor(EV_FIN, 1, FRAME_BUDGET, "stall_fin_seen");
    repeat (5) step();
    checkOutput("stall_en", n_en, CW_NUM * CW_LEN);
    checkOutput("stall_last", n_last, CW_NUM);
    checkOutput("stall_gap", n_gap, 0);

    // Frame ready while busy: first is queued, second is lost
    clearStats();
    applyStimulus(1'b1, 1'b1);
    waitFor(EV_START, 2, FRAME_BUDGET, "pend_cw1_start");
    applyStimulus(1'b1, 1'b1);
    checkOutput("pend_no_ovf", int'(frm_ovf), 0);
    waitFor(EV_START, 5, FRAME_BUDGET, "pend_cw4_start");
    applyStimulus(1'b1, 1'b1);
    step();
    checkOutput("pend_ovf", int'(frm_ovf), 1);
    waitFor(EV_FIN, 1, FRAME_BUDGET, "pend_fin1_seen");
    checkOutput("pend_after_fin", n_start, CW_NUM);
    waitFor(EV_FIN, 2, FRAME_BUDGET, "pend_fin2_seen");
    repeat (5) step();
    checkOutput("pend_starts", n_start, 2 * CW_NUM);
    checkOutput("pend_en", n_en, 2 * CW_NUM * CW_LEN);
    checkOutput("pend_req", n_req, 2 * CW_NUM * CW_LEN);
    checkOutput("pend_rd_err", int'(rd_err), 0);

    // Deinterleaver loses the last two samples of codeword 0
    clearStats();
    drop_mode = 1;
    applyStimulus(1'b1, 1'b1);
    waitFor(EV_FIN, 1, CW_LEN + 100, "drop_fin_seen");
    checkOutput("drop_rd_err", int'(rd_err), 1);
    checkOutput("drop_cw_idx", int'(cw_idx), 0);
    checkOutput("drop_no_last", n_last, 0);
    checkOutput("drop_en", n_en, CW_LEN - 2);
    checkOutput("drop_timeout_cycles", fin_cyc - en_cyc, 16);
    drop_mode = 0;
    req_before = n_req;
    repeat (30) step();
    checkOutput("drop_idle_req", n_req - req_before, 0);
    checkOutput("drop_fin_once", n_fin, 1);
    checkOutput("drop_sb_empty", sb.size(), 0);
    model_cnt = 0;
    model_cw = 0;
    exp_cw = 0;
    in_cw = 0;

    // Reset in the middle of codeword 7
    clearStats();
    applyStimulus(1'b1, 1'b1);
    waitFor(EV_START, 8, FRAME_BUDGET, "rst_cw7_start");
    repeat (20) step();
    checkOutput("pre_rst_req", int'(ldpc_req), 1);
    checkOutput("pre_rst_sticky", int'({frm_ovf, rd_err}), 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", int'(ldpc_req), 0);
    checkOutput("mid_rst_dec", int'({dec_start, dec_din_en, dec_last, ldpc_fin}), 0);
    checkOutput("mid_rst_din", int'(dec_din), 0);
    checkOutput("mid_rst_cw_idx", int'(cw_idx), 0);
    checkOutput("mid_rst_sticky", int'({frm_ovf, rd_err}), 0);
    sb.delete();
    repeat (3) step();
    model_cnt = 0;
    model_cw = 0;
    exp_cw = 0;
    rst_n = 1'b1;
    clearStats();
    repeat (30) step();
    checkOutput("post_rst_no_req", n_req, 0);
    checkOutput("post_rst_no_en", n_en, 0);

    // Stray sample while idle
    inject = 1;
    repeat (4) step();
    checkOutput("stray_rd_err", int'(rd_err), 1);
    checkOutput("stray_not_fwd", n_en, 0);

    applyStimulus(1'b1, 1'b1);
    waitFor(EV_FIN, 1, FRAME_BUDGET, "post_rst_fin_seen");
    repeat (5) step();
    checkOutput("post_rst_starts", n_start, CW_NUM);
    checkOutput("post_rst_en", n_en, CW_NUM * CW_LEN);
    checkOutput("post_rst_ovf", int'(frm_ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
